// File: rtl/fetch_ctrl_if.sv
// =============================================================================
//  fetch_ctrl_if : pipeline-side hazard/redirect bundle for fetch_ctrl
//  Revision      : 1.0  initial release
// =============================================================================
`default_nettype none

interface fetch_ctrl_if #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
);
   logic [4:0]            id_rs1_i;
   logic [4:0]            id_rs2_i;
   logic [4:0]            ex_rd_i;
   logic                  ex_mem_read_i;
   logic                  ex_br_taken_i;
   logic [DATA_WIDTH-1:0] ex_br_target_i;
   logic                  imem_ready_i;
   logic                  clr_cnt_i;
   logic [1:0]            pc_stall_o;
   logic                  pc_sel_o;
   logic [DATA_WIDTH-1:0] pc_imm_o;
   logic                  ifid_stall_o;
   logic                  ifid_flush_o;
   logic                  idex_flush_o;
   logic                  pend_o;
   logic [CNT_WIDTH-1:0]  stall_cnt_o;
   logic [CNT_WIDTH-1:0]  redir_cnt_o;

   modport master (
      output id_rs1_i, id_rs2_i, ex_rd_i, ex_mem_read_i, ex_br_taken_i,
             ex_br_target_i, imem_ready_i, clr_cnt_i,
      input  pc_stall_o, pc_sel_o, pc_imm_o, ifid_stall_o, ifid_flush_o,
             idex_flush_o, pend_o, stall_cnt_o, redir_cnt_o
   );

   modport slave (
      input  id_rs1_i, id_rs2_i, ex_rd_i, ex_mem_read_i, ex_br_taken_i,
             ex_br_target_i, imem_ready_i, clr_cnt_i,
      output pc_stall_o, pc_sel_o, pc_imm_o, ifid_stall_o, ifid_flush_o,
             idex_flush_o, pend_o, stall_cnt_o, redir_cnt_o
   );
endinterface

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// =============================================================================
//  fetch_ctrl : PC/pipeline-register control for load-use stalls and redirects
//  Revision   : 1.0  initial release
// =============================================================================
`default_nettype none

module fetch_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  wire           clk_i,
   input  wire           rst_i,
   fetch_ctrl_if.slave   bus
);
   typedef enum logic [0:0] {RUN = 1'b0, PEND = 1'b1} state_t;

   state_t                state;
   state_t                next_state;
   logic [DATA_WIDTH-1:0] tgt_q;
   logic                  load_tgt;
   logic [CNT_WIDTH-1:0]  stall_cnt_q;
   logic [CNT_WIDTH-1:0]  redir_cnt_q;
   logic                  load_use;
   logic [1:0]            pc_stall;
   logic                  pc_sel;
   logic [DATA_WIDTH-1:0] pc_imm;
   logic                  ifid_stall;
   logic                  ifid_flush;
   logic                  idex_flush;

   assign load_use = bus.ex_mem_read_i && (bus.ex_rd_i != 5'd0) &&
                     ((bus.ex_rd_i == bus.id_rs1_i) || (bus.ex_rd_i == bus.id_rs2_i));

   always_comb begin
      pc_stall   = 2'b00;
      pc_sel     = 1'b0;
      pc_imm     = tgt_q;
      ifid_stall = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      load_tgt   = 1'b0;
      next_state = state;
      if (rst_i) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         next_state = RUN;
      end else begin
         case (state)
            RUN: begin
               if (bus.ex_br_taken_i) begin
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
                  if (bus.imem_ready_i) begin
                     pc_sel = 1'b1;
                     pc_imm = bus.ex_br_target_i;
                  end else begin
                     // imem busy: remember the target and replay it once fetch is ready
                     pc_stall   = 2'b01;
                     load_tgt   = 1'b1;
                     next_state = PEND;
                  end
               end else if (load_use) begin
                  pc_stall   = 2'b01;
                  ifid_stall = 1'b1;
                  idex_flush = 1'b1;
               end else if (!bus.imem_ready_i) begin
                  pc_stall   = 2'b01;
                  ifid_flush = 1'b1;
               end
            end
            PEND: begin
               // ID/EX only hold bubbles here, so branch and hazard inputs are ignored
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
               if (bus.imem_ready_i) begin
                  pc_sel     = 1'b1;
                  next_state = RUN;
               end else begin
                  pc_stall = 2'b01;
               end
            end
            default: next_state = RUN;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= RUN;
         tgt_q       <= '0;
         stall_cnt_q <= '0;
         redir_cnt_q <= '0;
      end else begin
         state <= next_state;
         if (load_tgt) begin
            tgt_q <= bus.ex_br_target_i;
         end
         if (bus.clr_cnt_i) begin
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
         end else begin
            if ((pc_stall == 2'b01) && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
               stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (pc_sel && (redir_cnt_q != {CNT_WIDTH{1'b1}})) begin
               redir_cnt_q <= redir_cnt_q + 1'b1;
            end
         end
      end
   end

   assign bus.pc_stall_o   = pc_stall;
   assign bus.pc_sel_o     = pc_sel;
   assign bus.pc_imm_o     = pc_imm;
   assign bus.ifid_stall_o = ifid_stall;
   assign bus.ifid_flush_o = ifid_flush;
   assign bus.idex_flush_o = idex_flush;
   assign bus.pend_o       = (state == PEND) && !rst_i;
   assign bus.stall_cnt_o  = stall_cnt_q;
   assign bus.redir_cnt_o  = redir_cnt_q;
endmodule

`default_nettype wire
